// File: rtl/keypad_event_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_event_ctrl
//
// Turns raw USB keycode reports (NUM_SLOTS packed 8-bit codes from the Nios
// keycode PIO) into per-frame movement events. Each of NUM_ACTIONS actions has
// its own small FSM that issues one step on a fresh press. With auto-repeat
// built in, a held key also re-steps after REPEAT_DELAY frames and then every
// REPEAT_RATE frames. Steps are aligned to the synchronised vsync so that
// frame_clk-clocked logic sees each step exactly once.
//
// Build option:
//   KEYPAD_AUTOREPEAT_EN  defined   -> DELAY/REPEAT auto-repeat path is built
//                         undefined -> single step per press, then HOLD until
//                                      release (REPEAT_* parameters ignored)
//
// Ports:
//   Clk         in   system clock
//   Reset       in   asynchronous, active-high reset
//   frame_clk   in   VGA vsync, asynchronous to Clk
//   keycode     in   NUM_SLOTS*8 raw report; slot s at [8s+7:8s]
//   act_held    out  registered raw level: action code present in any slot
//   act_step    out  movement event, held for one full frame period
//   last_act    out  one-hot of the last action that stepped (LEDs)
//   last_code   out  last nonzero code seen in slot 0 (hex display)
//   frame_tick  out  one-Clk pulse per synchronised vsync rising edge
// -----------------------------------------------------------------------------
module keypad_event_ctrl #(
  parameter int unsigned                  NUM_SLOTS    = 2,
  parameter int unsigned                  NUM_ACTIONS  = 4,
  parameter logic [NUM_ACTIONS*8-1:0]     ACT_CODES    = {8'h52, 8'h51, 8'h50, 8'h4F},
  parameter int unsigned                  REPEAT_DELAY = 15,
  parameter int unsigned                  REPEAT_RATE  = 6
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic [NUM_SLOTS*8-1:0]   keycode,
  output logic [NUM_ACTIONS-1:0]   act_held,
  output logic [NUM_ACTIONS-1:0]   act_step,
  output logic [NUM_ACTIONS-1:0]   last_act,
  output logic [7:0]               last_code,
  output logic                     frame_tick
);

  localparam int unsigned CODE_W = 8;

`ifdef KEYPAD_AUTOREPEAT_EN
  // A zero delay/rate is treated as one frame.
  localparam int unsigned DELAY_EFF = (REPEAT_DELAY == 0) ? 1 : REPEAT_DELAY;
  localparam int unsigned RATE_EFF  = (REPEAT_RATE == 0) ? 1 : REPEAT_RATE;
  localparam int unsigned CNT_MAX   = (DELAY_EFF > RATE_EFF) ? DELAY_EFF : RATE_EFF;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;
`endif

  // Synchroniser and edge detect for vsync
  logic fc_meta_q;
  logic fc_sync_q;
  logic fc_prev_q;

  // Decode / press detection
  logic [NUM_ACTIONS-1:0] hit_c;
  logic [NUM_ACTIONS-1:0] hit_m_c;
  logic [NUM_ACTIONS-1:0] hit_m_q;
  logic [NUM_ACTIONS-1:0] rise_c;
  logic                   armed_q;

  // Per-action FSM state
  state_t                 state_q   [NUM_ACTIONS];
  logic [NUM_ACTIONS-1:0] pending_q;
  logic [NUM_ACTIONS-1:0] step_c;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CNT_W-1:0]       cnt_q     [NUM_ACTIONS];
  logic [CNT_W-1:0]       cnt_inc_c [NUM_ACTIONS];
`endif

  // Highest-index set bit as a one-hot vector
  function automatic logic [NUM_ACTIONS-1:0] top_onehot(input logic [NUM_ACTIONS-1:0] v);
    logic [NUM_ACTIONS-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_ACTIONS); i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Action hit: code present in any slot; 8'h00 (no key) never matches
  always_comb begin
    hit_c = '0;
    for (int a = 0; a < int'(NUM_ACTIONS); a++) begin
      for (int s = 0; s < int'(NUM_SLOTS); s++) begin
        if ((ACT_CODES[a*CODE_W +: CODE_W] != 8'h00) &&
            (keycode[s*CODE_W +: CODE_W] == ACT_CODES[a*CODE_W +: CODE_W])) begin
          hit_c[a] = 1'b1;
        end
      end
    end
  end

  // Opposing pairs (0,1), (2,3), ... cancel each other for the FSMs
  always_comb begin
    hit_m_c = hit_c;
    for (int p = 0; p + 1 < int'(NUM_ACTIONS); p += 2) begin
      if (hit_c[p] && hit_c[p+1]) begin
        hit_m_c[p]   = 1'b0;
        hit_m_c[p+1] = 1'b0;
      end
    end
  end

  // armed_q suppresses a false press for a level already high out of reset
  assign rise_c = hit_m_c & ~hit_m_q & {NUM_ACTIONS{armed_q}};

  // Step decision, only meaningful on a frame tick
  always_comb begin
    step_c = '0;
    for (int a = 0; a < int'(NUM_ACTIONS); a++) begin
`ifdef KEYPAD_AUTOREPEAT_EN
      cnt_inc_c[a] = cnt_q[a] + CNT_W'(1);
      case (state_q[a])
        ST_IDLE:   step_c[a] = pending_q[a] | rise_c[a];
        ST_DELAY:  step_c[a] = hit_m_c[a] && (cnt_inc_c[a] == CNT_W'(DELAY_EFF));
        ST_REPEAT: step_c[a] = hit_m_c[a] && (cnt_inc_c[a] == CNT_W'(RATE_EFF));
        default:   step_c[a] = 1'b0;
      endcase
`else
      step_c[a] = (state_q[a] == ST_IDLE) && (pending_q[a] || rise_c[a]);
`endif
    end
    step_c = step_c & {NUM_ACTIONS{frame_tick}};
  end

  // Sync, decode registers, outputs and per-action FSMs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_meta_q  <= 1'b0;
      fc_sync_q  <= 1'b0;
      fc_prev_q  <= 1'b0;
      frame_tick <= 1'b0;
      act_held   <= '0;
      act_step   <= '0;
      last_act   <= '0;
      last_code  <= '0;
      hit_m_q    <= '0;
      armed_q    <= 1'b0;
      pending_q  <= '0;
      for (int a = 0; a < int'(NUM_ACTIONS); a++) begin
        state_q[a] <= ST_IDLE;
`ifdef KEYPAD_AUTOREPEAT_EN
        cnt_q[a]   <= '0;
`endif
      end
    end else begin
      fc_meta_q  <= frame_clk;
      fc_sync_q  <= fc_meta_q;
      fc_prev_q  <= fc_sync_q;
      frame_tick <= fc_sync_q & ~fc_prev_q;

      act_held <= hit_c;
      hit_m_q  <= hit_m_c;
      armed_q  <= 1'b1;

      if (keycode[CODE_W-1:0] != 8'h00) begin
        last_code <= keycode[CODE_W-1:0];
      end

      // Steps hold for a whole frame so the vsync-clocked consumer sees each once
      if (frame_tick) begin
        act_step <= step_c;
        if (step_c != '0) begin
          last_act <= top_onehot(step_c);
        end
      end

      for (int a = 0; a < int'(NUM_ACTIONS); a++) begin
        case (state_q[a])
          ST_IDLE: begin
            if (frame_tick && (pending_q[a] || rise_c[a])) begin
              pending_q[a] <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
              state_q[a]   <= ST_DELAY;
              cnt_q[a]     <= '0;
`else
              state_q[a]   <= ST_HOLD;
`endif
            end else if (rise_c[a]) begin
              // A press shorter than a frame is remembered until the next tick
              pending_q[a] <= 1'b1;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          ST_DELAY: begin
            if (frame_tick) begin
              if (!hit_m_c[a]) begin
                state_q[a] <= ST_IDLE;
                cnt_q[a]   <= '0;
              end else if (cnt_inc_c[a] == CNT_W'(DELAY_EFF)) begin
                state_q[a] <= ST_REPEAT;
                cnt_q[a]   <= '0;
              end else begin
                cnt_q[a]   <= cnt_inc_c[a];
              end
            end
          end
          ST_REPEAT: begin
            if (frame_tick) begin
              if (!hit_m_c[a]) begin
                state_q[a] <= ST_IDLE;
                cnt_q[a]   <= '0;
              end else if (cnt_inc_c[a] == CNT_W'(RATE_EFF)) begin
                cnt_q[a]   <= '0;
              end else begin
                cnt_q[a]   <= cnt_inc_c[a];
              end
            end
          end
`else
          ST_HOLD: begin
            if (frame_tick && !hit_m_c[a]) begin
              state_q[a] <= ST_IDLE;
            end
          end
`endif
          default: begin
            state_q[a] <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_event_ctrl
//
// Self-checking bench for keypad_event_ctrl. A reference model counts how many
// frames each action has been held since its first step and derives steps from
// that count arithmetically; every DUT output is compared with it each Clk.
// Directed scenarios plus a randomized keycode/reset phase.
// -----------------------------------------------------------------------------
module tb_keypad_event_ctrl;

  localparam int unsigned D_FR = 15;
  localparam int unsigned R_FR = 6;
  localparam logic [7:0]  CODES [4] = '{8'h4F, 8'h50, 8'h51, 8'h52};

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [15:0] keycode;
  logic [3:0]  act_held;
  logic [3:0]  act_step;
  logic [3:0]  last_act;
  logic [7:0]  last_code;
  logic        frame_tick;

  keypad_event_ctrl #(
    .NUM_SLOTS    (2),
    .NUM_ACTIONS  (4),
    .ACT_CODES    ({8'h52, 8'h51, 8'h50, 8'h4F}),
    .REPEAT_DELAY (D_FR),
    .REPEAT_RATE  (R_FR)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .act_held   (act_held),
    .act_step   (act_step),
    .last_act   (last_act),
    .last_code  (last_code),
    .frame_tick (frame_tick)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [3:0] m_held, m_step, m_last_act, m_pend, m_prev;
  bit [7:0] m_last_code;
  bit       m_tick, m_armed;
  bit       h1, h2, h3;     // frame_clk as sampled 1, 2, 3 edges ago
  int       m_n [4];        // frames held since first step, -1 when released

  function automatic bit [3:0] decode(input logic [15:0] kc);
    bit [3:0] h;
    h = '0;
    for (int a = 0; a < 4; a++)
      if (kc[7:0] == CODES[a] || kc[15:8] == CODES[a]) h[a] = 1'b1;
    return h;
  endfunction

  function automatic bit [3:0] mask_opp(input bit [3:0] h);
    bit [3:0] m;
    m = h;
    if (h[0] && h[1]) m[1:0] = 2'b00;
    if (h[2] && h[3]) m[3:2] = 2'b00;
    return m;
  endfunction

  function automatic bit repeat_due(input int n);
`ifdef KEYPAD_AUTOREPEAT_EN
    return (n == int'(D_FR)) || (n > int'(D_FR) && ((n - int'(D_FR)) % int'(R_FR)) == 0);
`else
    return (n < 0);
`endif
  endfunction

  function automatic bit [3:0] top1(input bit [3:0] v);
    bit [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 4'(1 << i);
    return r;
  endfunction

  task automatic model_reset();
    m_held = '0; m_step = '0; m_last_act = '0; m_pend = '0; m_prev = '0;
    m_last_code = '0; m_tick = 1'b0; m_armed = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    for (int a = 0; a < 4; a++) m_n[a] = -1;
  endtask

  // Advance the model across one Clk rising edge with the given inputs
  task automatic model_edge(input logic [15:0] kc, input logic fcv);
    bit       tick_now;
    bit [3:0] hm, rise, steps;
    tick_now = m_tick;
    hm    = mask_opp(decode(kc));
    rise  = hm & ~m_prev & {4{m_armed}};
    steps = '0;
    for (int a = 0; a < 4; a++) begin
      if (m_n[a] < 0) begin
        if (tick_now && (m_pend[a] || rise[a])) begin
          steps[a] = 1'b1;
          m_n[a]   = 0;
          m_pend[a] = 1'b0;
        end else if (rise[a]) begin
          m_pend[a] = 1'b1;
        end
      end else if (tick_now) begin
        if (!hm[a]) m_n[a] = -1;
        else begin
          m_n[a]++;
          if (repeat_due(m_n[a])) steps[a] = 1'b1;
        end
      end
    end
    if (tick_now) begin
      m_step = steps;
      if (steps != '0) m_last_act = top1(steps);
    end
    m_tick = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = fcv;
    m_held  = decode(kc);
    m_prev  = hm;
    m_armed = 1'b1;
    if (kc[7:0] != 8'h00) m_last_code = kc[7:0];
  endtask

  // ---------------- stimulus helpers ----------------
  logic [15:0] kc_drv;
  int          fc_cnt  = 0;
  int          fc_half = 10;
  bit          tick_seen = 1'b0;
  bit [3:0]    frame_steps [$];
  int          frames_seen = 0;

  task automatic drive_fc();
    fc_cnt++;
    if (fc_cnt >= fc_half) begin
      frame_clk = ~frame_clk;
      fc_cnt    = 0;
      fc_half   = int'($urandom_range(8, 14));
    end
  endtask

  task automatic check_outputs();
    check("act_held",   act_held,   m_held);
    check("act_step",   act_step,   m_step);
    check("last_act",   last_act,   m_last_act);
    check("last_code",  last_code,  m_last_code);
    check("frame_tick", frame_tick, m_tick);
  endtask

  // One Clk: check what the last edge produced, then set up the next edge
  task automatic cyc();
    @(negedge Clk);
    check_outputs();
    if (tick_seen) begin
      frame_steps.push_back(act_step);
      frames_seen++;
    end
    tick_seen = m_tick;
    drive_fc();
    keycode = kc_drv;
    model_edge(keycode, frame_clk);
  endtask

  task automatic run_frames(input int n);
    int start;
    int budget;
    start  = frames_seen;
    budget = n * 40 + 50;
    while ((frames_seen - start) < n && budget > 0) begin
      cyc();
      budget--;
    end
    if ((frames_seen - start) < n) check("frame_timeout", frames_seen - start, n);
  endtask

  task automatic do_reset(input int n);
    @(negedge Clk);
    check_outputs();
    Reset = 1'b1;
    model_reset();
    tick_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check("rst_held", act_held, 4'b0000);
      check("rst_step", act_step, 4'b0000);
      check("rst_last_act", last_act, 4'b0000);
      check("rst_last_code", last_code, 8'h00);
      check("rst_tick", frame_tick, 1'b0);
      drive_fc();
      keycode = kc_drv;
      if (i == n - 1) begin
        Reset = 1'b0;
        model_edge(keycode, frame_clk);
      end
    end
  endtask

  function automatic logic [7:0] pick_code();
    int r;
    r = int'($urandom_range(0, 7));
    if (r < 3) return 8'h00;
    if (r < 7) return CODES[r-3];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic start_scenario();
    frame_steps.delete();
    repeat (5) cyc();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int       exp_q [$];
    int       got_q [$];
    int       len;

    Reset     = 1'b1;
    frame_clk = 1'b0;
    kc_drv    = 16'h0052;
    keycode   = kc_drv;
    model_reset();

    // Up held through reset: no step afterwards
    do_reset(4);
    frame_steps.delete();
    run_frames(3);
    for (int i = 0; i < 3; i++) check("held_thru_rst_step", frame_steps[i], 4'b0000);
    check("held_thru_rst_level", act_held, 4'b1000);
    kc_drv = 16'h0000;
    run_frames(2);

    // Up pressed for 2 frames: one step in the first frame only
    start_scenario();
    kc_drv = 16'h0052;
    run_frames(2);
    kc_drv = 16'h0000;
    run_frames(2);
    check("up_f1", frame_steps[0], 4'b1000);
    for (int i = 1; i < 4; i++) check("up_later", frame_steps[i], 4'b0000);
    check("up_last_act", last_act, 4'b1000);
    check("up_last_code", last_code, 8'h52);

    // Right held 30 frames
    start_scenario();
    kc_drv = 16'h004F;
    run_frames(30);
    kc_drv = 16'h0000;
    run_frames(2);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_q = '{1, 16, 22, 28};
`else
    exp_q = '{1};
`endif
    got_q.delete();
    for (int i = 0; i < frame_steps.size(); i++) begin
      if (frame_steps[i][0]) got_q.push_back(i + 1);
      check("rpt_other_bits", frame_steps[i][3:1], 3'b000);
    end
    check("rpt_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check("rpt_frame", got_q[i], exp_q[i]);
    check("rpt_last_act", last_act, 4'b0001);

    // Up and down together cancel
    start_scenario();
    kc_drv = 16'h5152;
    run_frames(3);
    check("opp_held", act_held, 4'b1100);
    kc_drv = 16'h0000;
    run_frames(2);
    for (int i = 0; i < 5; i++) check("opp_step", frame_steps[i], 4'b0000);

    // Short left pulse within a frame
    start_scenario();
    kc_drv = 16'h0050;
    repeat (10) cyc();
    kc_drv = 16'h0000;
    run_frames(2);
    check("pulse_f1", frame_steps[0], 4'b0010);
    check("pulse_f2", frame_steps[1], 4'b0000);
    check("pulse_last_act", last_act, 4'b0010);

    // Duplicate code in both slots acts as a single hit
    start_scenario();
    kc_drv = 16'h4F4F;
    run_frames(3);
    check("dup_held", act_held, 4'b0001);
    kc_drv = 16'h0000;
    run_frames(2);
    check("dup_f1", frame_steps[0], 4'b0001);
    for (int i = 1; i < 5; i++) check("dup_later", frame_steps[i], 4'b0000);

    // Randomized reports with occasional long holds and resets
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 29) == 0) do_reset(int'($urandom_range(2, 5)));
      kc_drv = {pick_code(), pick_code()};
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(300, 700))
                                        : int'($urandom_range(1, 60));
      repeat (len) cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_event_ctrl.md
Name: keypad_event_ctrl

Overview:
- Turns raw USB keycode reports from the Nios keycode PIO into per-frame movement events for the frog and other game logic.
- Generalises the inline arrow-key decode to N report slots and N configurable actions.
- Adds press-edge stepping, frame-timed auto-repeat, opposing-key masking and a latched last-action indicator for the LEDs.
- Sits in the top level between `nios_system.keycode_export` and the frog/LED/HEX logic.

Parameters:
- NUM_SLOTS, 2, number of 8-bit keycodes packed in `keycode`; slot s occupies bits [8s+7:8s].
- NUM_ACTIONS, 4, number of decoded actions.
- ACT_CODES, {8'h52, 8'h51, 8'h50, 8'h4F}, packed codes; action 0 = 8'h4F right, 1 = 8'h50 left, 2 = 8'h51 down, 3 = 8'h52 up.
- REPEAT_DELAY, 15, frames a key must stay held after its first step before repeat begins.
- REPEAT_RATE, 6, frames between repeat steps.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  VGA vsync; asynchronous to Clk.
- keycode  in  NUM_SLOTS*8  raw report from the PIO.
- act_held  out  NUM_ACTIONS  registered level: action code present in any slot.
- act_step  out  NUM_ACTIONS  movement event; high for exactly one frame period.
- last_act  out  NUM_ACTIONS  one-hot, last action that produced a step (drives LEDG).
- last_code  out  8  last nonzero keycode seen in slot 0 (drives HEX0/HEX1).
- frame_tick  out  1  single-Clk pulse on each synchronised vsync rising edge.

Behaviour:
- Reset (async): all outputs 0, all FSMs in IDLE, counters 0, pending flags 0, synchroniser flops 0.
- Frame sync:
  - frame_clk passes through a 2-flop synchroniser plus an edge register.
  - frame_tick asserts for 1 Clk on a 0->1 transition, 3 Clk after the raw edge.
- Decode:
  - hit[a] = OR over slots of (slot == ACT_CODES[a]); code 8'h00 never matches.
  - Duplicate codes across slots count as one hit.
  - act_held <= hit, registered every Clk (1-cycle latency).
- Opposing mask: pairs are (0,1) and (2,3). If both members of a pair are held, both are treated as not held for FSM purposes; act_held still reports raw state.
- Per-action FSM, evaluated each Clk, with state/counter changes on frame_tick only:
  - IDLE: masked hit rising (Clk domain) sets pending[a]. On frame_tick with pending: go to DELAY, count = 0, step issued, pending cleared.
  - DELAY: on frame_tick, if held then count++, and on count == REPEAT_DELAY go to REPEAT with count = 0 and step issued. If not held, go to IDLE.
  - REPEAT: on frame_tick, if held then count++, and on count == REPEAT_RATE issue a step with count = 0. If not held, go to IDLE.
- Press and release within one frame: pending remains set, so exactly one step is issued at the next tick.
- Step output: on a frame_tick, act_step[a] <= step_issued[a]. It holds until the next frame_tick, so the frame_clk-clocked frog samples it exactly once.
- last_act: loads the one-hot of the highest-index issued step on any tick that issues a step. Otherwise it holds.
- last_code: loads slot 0 when slot 0 != 0; holds otherwise.
- Counters are $clog2(max(REPEAT_DELAY, REPEAT_RATE) + 1) bits wide.
- REPEAT_DELAY = 0 or REPEAT_RATE = 0 behaves as 1.
- Reset mid-hold: all state is cleared. A key still held after reset release counts as a new press on its next rising hit only; a level already high produces no step.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: DELAY/REPEAT behaviour exactly as above.
- Undefined:
  - DELAY/REPEAT logic and counters are not built.
  - After the first step, a held key stays in a HOLD state with no further steps until released.
  - REPEAT_DELAY and REPEAT_RATE are ignored.

Test Plan:
- Reset asserted with keycode = 16'h0052 -> all outputs 0; after release with 16'h0052 still applied, act_step stays 0 because there is no rising hit.
- Apply 16'h0052, hold 2 frames, release -> act_step = 4'b1000 for exactly the first frame after the press, last_act = 4'b1000, last_code = 8'h52.
- Hold 16'h004F for 30 frames (REPEAT_DELAY = 15, REPEAT_RATE = 6) -> steps in frames 1, 16, 22 and 28 only. Without KEYPAD_AUTOREPEAT_EN -> frame 1 only.
- keycode = 16'h5152 (up and down together) -> act_held = 4'b1100 and act_step = 0 throughout.
- Pulse 16'h0050 for 10 Clk mid-frame, then 0 -> act_step = 4'b0010 for the following frame only.
- keycode = 16'h4F4F -> act_held[0] = 1 and a single step, identical to 16'h004F.
